// File: rtl/lilme_pkg.sv
// Shared types and constants for the matrix-engine command issuer.
package lilme_pkg;

  localparam logic [2:0] ME_NOP = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [2:0] me;
    logic       a;
    logic       b;
  } cmd_t;

  localparam int unsigned CmdW = $bits(cmd_t);

endpackage

// File: rtl/lilme_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module lilme_cmd_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [Width-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/lilme_cmd_issuer.sv
// Queues engine commands and issues them one at a time, capturing each result.
// Optional watchdog: define LILME_CMD_TIMEOUT_EN.
module lilme_cmd_issuer
  import lilme_pkg::*;
#(
  parameter int unsigned dw      = 31,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_me_op,
  input  logic        cmd_a_op,
  input  logic        cmd_b_op,
  output logic [2:0]  ME_opcode,
  output logic        A_opcode,
  output logic        B_opcode,
  input  logic        Busy,
  input  logic [dw:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [dw:0] rsp_data,
  output logic        rsp_err,
  output logic        idle
);

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [dw:0] rsp_data_q, rsp_data_d;
  logic        fifo_pop, fifo_full, fifo_empty;
  cmd_t        push_cmd, head;

`ifdef LILME_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT);
  logic          rsp_err_q, rsp_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign push_cmd = '{me: cmd_me_op, a: cmd_a_op, b: cmd_b_op};

  lilme_cmd_fifo #(
    .Width (CmdW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;
    ME_opcode   = ME_NOP;
    A_opcode    = 1'b0;
    B_opcode    = 1'b0;
`ifdef LILME_CMD_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
`endif
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !rsp_valid_q && !Busy) state_d = StIssue;
      end
      StIssue: begin
        fifo_pop = 1'b1;
        // NOP commands are consumed silently and never reach the engine.
        if (head.me == ME_NOP) begin
          state_d = StIdle;
        end else begin
          ME_opcode = head.me;
          A_opcode  = head.a;
          B_opcode  = head.b;
          state_d   = StWaitBusy;
        end
`ifdef LILME_CMD_TIMEOUT_EN
        tmo_d = TW'(1);
`endif
      end
      StWaitBusy: begin
        if (Busy) state_d = StRun;
      end
      StRun: begin
        if (!Busy) begin
          state_d     = StDone;
          rsp_valid_d = 1'b1;
          rsp_data_d  = result;
`ifdef LILME_CMD_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef LILME_CMD_TIMEOUT_EN
    if ((state_q == StWaitBusy || state_q == StRun) && state_d != StDone) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TmoLimit) begin
        state_d     = StDone;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef LILME_CMD_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef LILME_CMD_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd_ready = !fifo_full;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = fifo_empty && (state_q == StIdle);
`ifdef LILME_CMD_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
